// File: rtl/pll_lock_detector.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | pll_lock_detector: counts Mon_Clk edges per Ref_Clk window, flags lock  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module pll_lock_detector #(
  parameter int WINDOW   = 16,
  parameter int RATIO    = 5,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             Ref_Clk,
  input  logic             Rst,
  input  logic             Mon_Clk,
  output logic             Locked,
  output logic             Lost_Lock,
  output logic [CNT_W-1:0] Freq_Count,
  output logic [1:0]       State
);

  localparam int WC_W = $clog2(WINDOW);
  localparam int GC_W = $clog2(LOCK_CNT + 1);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LO_BOUND = CNT_W'(WINDOW * RATIO - TOL);
  localparam logic [CNT_W-1:0] HI_BOUND = CNT_W'(WINDOW * RATIO + TOL);
  localparam logic [GC_W-1:0]  LOCK_V   = GC_W'(LOCK_CNT);
  localparam logic [GC_W-1:0]  GOOD_ONE = GC_W'(1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  // ---------------- Mon_Clk domain ----------------
  logic [1:0]       mon_rst_q;
  logic [CNT_W-1:0] mon_cnt_q;
  logic [CNT_W-1:0] mon_cnt_d;
  logic [CNT_W-1:0] mon_gray_q;

  assign mon_cnt_d = mon_cnt_q + 1'b1;

  always_ff @(posedge Mon_Clk) begin
    mon_rst_q <= {mon_rst_q[0], Rst};
  end

  always_ff @(posedge Mon_Clk) begin
    if (!mon_rst_q[1]) begin
      mon_cnt_q  <= '0;
      mon_gray_q <= '0;
    end else begin
      mon_cnt_q  <= mon_cnt_d;
      mon_gray_q <= mon_cnt_d ^ (mon_cnt_d >> 1);
    end
  end

  // ---------------- Ref_Clk domain ----------------
  // Only the Gray-coded count crosses, so a mid-transition capture is off by at most one.
  logic [CNT_W-1:0] gray_s1_q;
  logic [CNT_W-1:0] gray_s2_q;
  logic [CNT_W-1:0] cur;

  always_ff @(posedge Ref_Clk) begin
    gray_s1_q <= mon_gray_q;
    gray_s2_q <= gray_s1_q;
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < CNT_W; i++) begin
      cur[i] = ^(gray_s2_q >> i);
    end
  end

  logic [WC_W-1:0]  win_cnt_q;
  logic             first_q;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] freq_q;
  state_e           state_q, state_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
  logic             lost_q, lost_d;
  logic             locked_q;

  logic             sample;
  logic             eval;
  logic [CNT_W-1:0] delta;
  logic             good;
  logic [GC_W-1:0]  good_inc;

  assign sample   = (win_cnt_q == WIN_LAST);
  assign eval     = sample && !first_q;
  // Modular subtract absorbs counter wrap inside a window.
  assign delta    = cur - prev_q;
  assign good     = (delta >= LO_BOUND) && (delta <= HI_BOUND);
  assign good_inc = good_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    lost_d     = 1'b0;
    if (eval) begin
      unique case (state_q)
        UNLOCKED: begin
          if (good) begin
            good_cnt_d = GOOD_ONE;
            state_d    = (GOOD_ONE == LOCK_V) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (good) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_V) state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
            state_d    = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!good) begin
            good_cnt_d = '0;
            state_d    = UNLOCKED;
            lost_d     = 1'b1;
          end
        end
        default: begin
          good_cnt_d = '0;
          state_d    = UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge Ref_Clk) begin
    if (!Rst) begin
      win_cnt_q  <= '0;
      first_q    <= 1'b1;
      prev_q     <= '0;
      freq_q     <= '0;
      state_q    <= UNLOCKED;
      good_cnt_q <= '0;
      lost_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      win_cnt_q <= sample ? '0 : win_cnt_q + 1'b1;
      if (sample) begin
        prev_q <= cur;
        if (first_q) first_q <= 1'b0;
        else         freq_q  <= delta;
      end
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      lost_q     <= lost_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

  assign Locked     = locked_q;
  assign Lost_Lock  = lost_q;
  assign Freq_Count = freq_q;
  assign State      = state_q;

endmodule
`default_nettype wire
